// File: rtl/inv_sqrt_arbiter.sv
// inv_sqrt_arbiter: round-robin sharing of one fixed-latency inv_sqrt unit
// between N_REQ requesters. A tag pipe tracks {valid, id, err} alongside the
// unit, and results return in accept order through a credit-protected FIFO.
// Handshake: a requester transfers on a cycle where req_valid & req_ready are
// both high; a response transfers on a cycle where rsp_valid & rsp_ready are
// both high. req_ready never depends on rsp_ready in the same cycle.
module inv_sqrt_arbiter #(
  parameter int N_REQ      = 4,
  parameter int WIDTH      = 32,
  parameter int UNIT_LAT   = 6,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*WIDTH-1:0]     req_x,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       unit_valid_in,
  output logic [WIDTH-1:0]           unit_x,
  input  logic                       unit_valid_out,
  input  logic [WIDTH-1:0]           unit_inv_sqrt,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [WIDTH-1:0]           rsp_data,
  output logic                       rsp_err,
  output logic                       sync_err,
  output logic                       busy
);

  localparam int IDW = $clog2(N_REQ);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int BW  = $clog2(UNIT_LAT + 1);
  localparam logic [WIDTH-1:0] ERR_DATA = {1'b0, {(WIDTH-1){1'b1}}};

  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [UNIT_LAT-1:0] tag_v_q, tag_v_d, tag_err_q, tag_err_d;
  logic [IDW-1:0]   tag_id_q [UNIT_LAT];
  logic [IDW-1:0]   tag_id_d [UNIT_LAT];
  logic [WIDTH-1:0] mem_data_q [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_data_d [FIFO_DEPTH];
  logic [IDW-1:0]   mem_id_q [FIFO_DEPTH];
  logic [IDW-1:0]   mem_id_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_err_q, mem_err_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             sync_err_q, sync_err_d;
  // Blanking window after reset release: unit results issued before reset may
  // still emerge and must not be flagged as sync errors.
  logic [BW-1:0]    blank_q, blank_d;

  logic [IDW-1:0]   grant, idx_v;
  logic             found, credit_ok, accept, op_err;
  logic [WIDTH-1:0] operand;
  int               inflight;
  logic             fin_v, fin_err, exp_out, mismatch, push, pop;

  // Round-robin search from ptr, credit check on registered occupancy, issue.
  always_comb begin
    grant    = '0;
    idx_v    = '0;
    found    = 1'b0;
    inflight = 0;
    operand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_v = IDW'((int'(ptr_q) + k) % N_REQ);
      if (!found && req_valid[idx_v]) begin
        found = 1'b1;
        grant = idx_v;
      end
    end
    for (int i = 0; i < UNIT_LAT; i++) inflight = inflight + int'(tag_v_q[i]);
    credit_ok = (inflight + int'(count_q)) < FIFO_DEPTH;
    // Gating with rst keeps every output low while reset is held.
    accept = rst && credit_ok && found;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = accept && (grant == IDW'(i));
      if (grant == IDW'(i)) operand = req_x[i*WIDTH +: WIDTH];
    end
    op_err        = operand[WIDTH-1] || (operand == '0);
    unit_valid_in = accept && !op_err;
    unit_x        = unit_valid_in ? operand : '0;
    ptr_d         = accept ? IDW'((int'(grant) + 1) % N_REQ) : ptr_q;
  end

  // Tag pipe shift and the unit-output consistency check at the last stage.
  always_comb begin
    tag_v_d[0]   = accept;
    tag_err_d[0] = op_err;
    tag_id_d[0]  = grant;
    for (int i = 1; i < UNIT_LAT; i++) begin
      tag_v_d[i]   = tag_v_q[i-1];
      tag_err_d[i] = tag_err_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
    fin_v      = tag_v_q[UNIT_LAT-1];
    fin_err    = tag_err_q[UNIT_LAT-1];
    exp_out    = fin_v && !fin_err;
    mismatch   = (unit_valid_out != exp_out) && !((blank_q != '0) && !fin_v);
    push       = fin_v && !mismatch;
    sync_err_d = sync_err_q || mismatch;
    blank_d    = (blank_q != '0) ? blank_q - BW'(1) : blank_q;
  end

  // Response FIFO: write on push, head shown combinationally from registers.
  always_comb begin
    rsp_valid  = (count_q != '0);
    pop        = rsp_valid && rsp_ready;
    mem_data_d = mem_data_q;
    mem_id_d   = mem_id_q;
    mem_err_d  = mem_err_q;
    if (push) begin
      mem_data_d[wr_ptr_q] = fin_err ? ERR_DATA : unit_inv_sqrt;
      mem_id_d[wr_ptr_q]   = tag_id_q[UNIT_LAT-1];
      mem_err_d[wr_ptr_q]  = fin_err;
    end
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    rsp_id   = rsp_valid ? mem_id_q[rd_ptr_q]   : '0;
    rsp_data = rsp_valid ? mem_data_q[rd_ptr_q] : '0;
    rsp_err  = rsp_valid && mem_err_q[rd_ptr_q];
    sync_err = sync_err_q;
    busy     = (|tag_v_q) || rsp_valid;
  end

  // State registers; reset discards everything in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q      <= '0;
      tag_v_q    <= '0;
      tag_err_q  <= '0;
      mem_err_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      sync_err_q <= 1'b0;
      blank_q    <= BW'(UNIT_LAT);
      for (int i = 0; i < UNIT_LAT; i++) tag_id_q[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_id_q[i]   <= '0;
      end
    end else begin
      ptr_q      <= ptr_d;
      tag_v_q    <= tag_v_d;
      tag_err_q  <= tag_err_d;
      tag_id_q   <= tag_id_d;
      mem_data_q <= mem_data_d;
      mem_id_q   <= mem_id_d;
      mem_err_q  <= mem_err_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      sync_err_q <= sync_err_d;
      blank_q    <= blank_d;
    end
  end

endmodule

// File: tb/tb_inv_sqrt_arbiter.sv
// Bench for inv_sqrt_arbiter: behavioural inv_sqrt unit, scoreboard of
// expected responses in accept order, one task per scenario.
module tb_inv_sqrt_arbiter;
  localparam int N_REQ = 4;
  localparam int WIDTH = 32;
  localparam int UNIT_LAT = 6;
  localparam int FIFO_DEPTH = 8;
  localparam int IDW = 2;
  localparam int EW = IDW + 1 + WIDTH;
  localparam logic [31:0] V_ONE = 32'h01000000;
  localparam logic [31:0] V_FOUR = 32'h04000000;
  localparam logic [31:0] V_QTR = 32'h00400000;
  localparam logic [31:0] V_16 = 32'h10000000;
  localparam logic [31:0] OPS [6] = '{32'h01000000, 32'h04000000, 32'h00400000,
                                      32'h10000000, 32'h00000000, 32'h80000000};

  logic clk = 1'b0;
  logic rst;
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ*WIDTH-1:0] req_x;
  logic [N_REQ-1:0] req_ready;
  logic unit_valid_in;
  logic [WIDTH-1:0] unit_x;
  logic unit_valid_out;
  logic [WIDTH-1:0] unit_inv_sqrt;
  logic rsp_valid, rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic rsp_err, sync_err, busy;

  logic mdl_rst_n;
  logic inject;
  logic mu_v [UNIT_LAT];
  logic [31:0] mu_x [UNIT_LAT];

  logic [EW-1:0] exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;
  int acc_count = 0;
  int rsp_count = 0;
  int err_rsp_count = 0;
  int unit_issues = 0;
  int cyc = 0;
  logic hold_v = 1'b0;
  logic [EW-1:0] hold_e;

  // clock / reset block
  always #5 clk = ~clk;

  inv_sqrt_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .UNIT_LAT(UNIT_LAT),
                     .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x),
    .req_ready(req_ready), .unit_valid_in(unit_valid_in), .unit_x(unit_x),
    .unit_valid_out(unit_valid_out), .unit_inv_sqrt(unit_inv_sqrt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .sync_err(sync_err), .busy(busy));

  // behavioural unit: arithmetic via reals, independent of the scoreboard table
  function automatic logic [31:0] model_inv_sqrt(input logic [31:0] x);
    real r;
    if (x == 32'h0 || x[31]) return 32'h0;
    r = real'(x) / 16777216.0;
    return 32'($rtoi(16777216.0 / $sqrt(r) + 0.5));
  endfunction

  // unit model is not tied to the DUT reset, so late results really occur
  always @(posedge clk or negedge mdl_rst_n) begin
    if (!mdl_rst_n) begin
      for (int i = 0; i < UNIT_LAT; i++) begin
        mu_v[i] <= 1'b0;
        mu_x[i] <= 32'h0;
      end
    end else begin
      mu_v[0] <= unit_valid_in;
      mu_x[0] <= unit_x;
      for (int i = 1; i < UNIT_LAT; i++) begin
        mu_v[i] <= mu_v[i-1];
        mu_x[i] <= mu_x[i-1];
      end
    end
  end
  assign unit_valid_out = mu_v[UNIT_LAT-1] | inject;
  assign unit_inv_sqrt = mu_v[UNIT_LAT-1] ? model_inv_sqrt(mu_x[UNIT_LAT-1]) : 32'h0;

  // expected 1/sqrt(x) in Q8.24 for the operands used by the bench
  function automatic logic [31:0] exp_data(input logic [31:0] op);
    case (op)
      32'h01000000: return 32'h01000000;
      32'h04000000: return 32'h00800000;
      32'h00400000: return 32'h02000000;
      32'h10000000: return 32'h00400000;
      default:      return 32'hDEADBEEF;
    endcase
  endfunction

  // scoreboard: runs at every negedge through sample()
  task automatic monitor();
    logic [EW-1:0] got, e;
    logic [31:0] op;
    logic err;
    if (!rst) begin
      exp_q.delete();
      hold_v = 1'b0;
    end else begin
      got = {rsp_id, rsp_err, rsp_data};
      if (hold_v) begin
        tests_run++;
        if (rsp_valid !== 1'b1 || got !== hold_e) begin
          tests_failed++;
          $display("FAIL rsp_hold: got v=%b %h required v=1 %h", rsp_valid, got, hold_e);
        end
      end
      if (rsp_valid === 1'b1 && rsp_ready) begin
        tests_run++;
        rsp_count++;
        if (rsp_err === 1'b1) err_rsp_count++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL rsp_unexpected: got %h required none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            tests_failed++;
            $display("FAIL rsp_data: got id/err/data %h required %h", got, e);
          end
        end
      end
      hold_v = (rsp_valid === 1'b1) && !rsp_ready;
      hold_e = got;
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          op = req_x[i*WIDTH +: WIDTH];
          err = op[31] || (op == 32'h0);
          exp_q.push_back({IDW'(i), err, err ? 32'h7FFFFFFF : exp_data(op)});
          acc_count++;
        end
      end
      if (unit_valid_in === 1'b1) unit_issues++;
    end
  endtask

  // driver tasks
  task automatic sample();
    @(negedge clk);
    monitor();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_x(input int i, input logic [31:0] v);
    req_x[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    inject = 1'b0;
    sample(); adv(); sample(); adv();
    rst = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    req_valid = '0;
    rsp_ready = 1'b1;
    sample();
    while (busy && n < 60) begin
      adv(); sample(); n++;
    end
    tests_run++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_drain: got busy=%b pending=%0d required busy=0 pending=0",
               name, busy, exp_q.size());
    end
    adv();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rsp_ready = 1'b1;
    inject = 1'b0;
    req_valid = 4'hF;
    for (int i = 0; i < N_REQ; i++) set_x(i, V_ONE);
    sample();
    tests_run++;
    if ({req_ready, unit_valid_in, unit_x, rsp_valid, rsp_id, rsp_data, rsp_err, sync_err, busy} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got ready=%b uv=%b ux=%h rv=%b id=%0d d=%h e=%b se=%b busy=%b required all 0",
               req_ready, unit_valid_in, unit_x, rsp_valid, rsp_id, rsp_data, rsp_err, sync_err, busy);
    end
    adv();
    rst = 1'b1;
    req_valid = '0;
    sample();
    tests_run++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle: got busy=%b rsp_valid=%b required 0 0", busy, rsp_valid);
    end
    adv();
  endtask

  task automatic test_single();
    int acc_cyc, n;
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    set_x(0, V_ONE);
    sample();
    tests_run++;
    if (req_ready !== 4'b0001) begin
      tests_failed++;
      $display("FAIL single_grant: got %b required 0001", req_ready);
    end
    acc_cyc = cyc;
    adv();
    req_valid = '0;
    n = 0;
    sample();
    while (rsp_valid !== 1'b1 && n < 20) begin
      adv(); sample(); n++;
    end
    tests_run++;
    if (cyc - acc_cyc - 1 != UNIT_LAT) begin
      tests_failed++;
      $display("FAIL single_latency: got %0d required %0d", cyc - acc_cyc - 1, UNIT_LAT);
    end
    tests_run++;
    if ({rsp_id, rsp_err, rsp_data} !== {2'd0, 1'b0, 32'h01000000}) begin
      tests_failed++;
      $display("FAIL single_rsp: got id=%0d err=%b data=%h required 0 0 01000000",
               rsp_id, rsp_err, rsp_data);
    end
    adv();
    drain("single");
  endtask

  task automatic test_round_robin();
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    set_x(0, V_FOUR); set_x(1, V_QTR); set_x(2, V_ONE); set_x(3, V_16);
    for (int k = 0; k < 16; k++) begin
      sample();
      tests_run++;
      if (req_ready !== 4'(1 << (k % 4))) begin
        tests_failed++;
        $display("FAIL rr_grant[%0d]: got %b required %b", k, req_ready, 4'(1 << (k % 4)));
      end
      adv();
    end
    drain("rr");
  endtask

  task automatic test_backpressure();
    int acc0, rsp0;
    logic resumed;
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    for (int i = 0; i < N_REQ; i++) set_x(i, OPS[i]);
    acc0 = acc_count;
    rsp0 = rsp_count;
    for (int k = 0; k < 30; k++) begin
      sample(); adv();
    end
    sample();
    tests_run++;
    if (acc_count - acc0 != FIFO_DEPTH || req_ready !== 4'b0000) begin
      tests_failed++;
      $display("FAIL bp_credit: got accepts=%0d ready=%b required %0d 0000",
               acc_count - acc0, req_ready, FIFO_DEPTH);
    end
    adv();
    rsp_ready = 1'b1;
    resumed = 1'b0;
    for (int k = 0; k < 5; k++) begin
      sample();
      if (req_ready != '0) resumed = 1'b1;
      adv();
    end
    tests_run++;
    if (!resumed) begin
      tests_failed++;
      $display("FAIL bp_resume: got ready stuck 0 required issue after pop");
    end
    drain("bp");
    tests_run++;
    if (rsp_count - rsp0 != acc_count - acc0 || sync_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_count: got rsp=%0d acc=%0d sync_err=%b required equal and 0",
               rsp_count - rsp0, acc_count - acc0, sync_err);
    end
  endtask

  task automatic test_err_operands();
    logic [31:0] seq [6];
    logic pos;
    int iss0, err0;
    seq = '{32'h00000000, V_ONE, 32'h80000000, V_ONE, 32'h00000000, V_ONE};
    do_reset();
    rsp_ready = 1'b1;
    iss0 = unit_issues;
    err0 = err_rsp_count;
    for (int k = 0; k < 6; k++) begin
      req_valid = 4'b0001;
      set_x(0, seq[k]);
      pos = !seq[k][31] && seq[k] != 32'h0;
      sample();
      tests_run++;
      if (req_ready !== 4'b0001 || unit_valid_in !== pos || unit_x !== (pos ? seq[k] : 32'h0)) begin
        tests_failed++;
        $display("FAIL err_issue[%0d]: got ready=%b uv=%b ux=%h required 0001 %b %h",
                 k, req_ready, unit_valid_in, unit_x, pos, pos ? seq[k] : 32'h0);
      end
      adv();
    end
    drain("err");
    tests_run++;
    if (unit_issues - iss0 != 3 || err_rsp_count - err0 != 3) begin
      tests_failed++;
      $display("FAIL err_counts: got unit=%0d err_rsp=%0d required 3 3",
               unit_issues - iss0, err_rsp_count - err0);
    end
  endtask

  task automatic test_reset_midflight();
    logic seen;
    do_reset();
    rsp_ready = 1'b0;
    for (int i = 0; i < N_REQ; i++) set_x(i, V_ONE);
    req_valid = 4'b0001;
    sample(); adv(); sample(); adv();
    req_valid = '0;
    for (int k = 0; k < 8; k++) begin
      sample(); adv();
    end
    req_valid = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      sample(); adv();
    end
    sample();
    tests_run++;
    if (busy !== 1'b1 || rsp_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_preload: got busy=%b rsp_valid=%b required 1 1", busy, rsp_valid);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if ({req_ready, unit_valid_in, unit_x, rsp_valid, rsp_id, rsp_data, rsp_err, busy} !== '0) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs: got ready=%b uv=%b rv=%b d=%h busy=%b required all 0",
               req_ready, unit_valid_in, rsp_valid, rsp_data, busy);
    end
    adv(); sample(); adv();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      sample();
      if (rsp_valid !== 1'b0) seen = 1'b1;
      adv();
    end
    tests_run++;
    if (seen || sync_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_after_release: got rsp_seen=%b sync_err=%b required 0 0", seen, sync_err);
    end
    req_valid = 4'hF;
    sample();
    tests_run++;
    if (req_ready !== 4'b0001) begin
      tests_failed++;
      $display("FAIL mid_ptr: got %b required 0001", req_ready);
    end
    adv();
    drain("mid");
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 300; k++) begin
      req_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < N_REQ; i++) set_x(i, OPS[$urandom_range(0, 5)]);
      rsp_ready = ($urandom_range(0, 3) != 0);
      sample();
      tests_run++;
      if (!$onehot0(req_ready) || (req_ready & ~req_valid) != '0) begin
        tests_failed++;
        $display("FAIL b2b_ready[%0d]: got %b valid %b required one-hot subset", k, req_ready, req_valid);
      end
      adv();
    end
    drain("b2b");
    tests_run++;
    if (sync_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_sync: got %b required 0", sync_err);
    end
  endtask

  task automatic test_sync_err();
    do_reset();
    rsp_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      sample(); adv();
    end
    sample();
    tests_run++;
    if (sync_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL sync_pre: got %b required 0", sync_err);
    end
    adv();
    inject = 1'b1;
    sample(); adv();
    inject = 1'b0;
    sample();
    tests_run++;
    if (sync_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL sync_set: got %b required 1", sync_err);
    end
    adv();
    for (int k = 0; k < 5; k++) begin
      sample(); adv();
    end
    sample();
    tests_run++;
    if (sync_err !== 1'b1 || rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL sync_sticky: got sync_err=%b rsp_valid=%b required 1 0", sync_err, rsp_valid);
    end
    adv();
    do_reset();
    sample();
    tests_run++;
    if (sync_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL sync_clear: got %b required 0", sync_err);
    end
    adv();
  endtask

  initial begin
    rst = 1'b0;
    req_valid = '0;
    req_x = '0;
    rsp_ready = 1'b0;
    inject = 1'b0;
    mdl_rst_n = 1'b0;
    #2;
    mdl_rst_n = 1'b1;
    adv();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_err_operands();
    test_reset_midflight();
    test_back_to_back();
    test_sync_err();
    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
